user_move_ctrl: RTL and testbench
=================================

// Module: user_move_ctrl
// PURPOSE
//  Upstream sequencer for the player-sprite plot FSM. Once per N frame ticks it samples the
//  left/right buttons and updates the player X position (clamped to the play field).
//  It then issues an erase pass at the old position, followed by a draw pass at the new one.
//  Each pass is a one-cycle draw_en pulse; the pass ends when the plot FSM returns draw_done.
//  erase tells the pixel-colour mux to force black during the erase pass.
// PARAMETERS
//  X_INIT          146  reset X position (9b)
//  Y_POS           200  fixed player Y row (8b)
//  X_MIN           0    leftmost legal X
//  X_MAX           292  rightmost legal X (320 - sprite width 28)
//  STEP            2    pixels moved per accepted move
//  FRAMES_PER_MOVE 1    frame ticks per move evaluation (>=1)
//  TIMEOUT_CYCLES  1023 draw_done watchdog limit (used only with macro)
// PORTS
//  clk         in   1  system clock
//  resetn      in   1  synchronous active-low reset
//  frame_tick  in   1  one-cycle pulse per video frame
//  move_left   in   1  level, synchronised button
//  move_right  in   1  level, synchronised button
//  draw_done   in   1  plot FSM completion pulse
//  x_pos       out  9  sprite origin X to plot FSM
//  y_pos       out  8  sprite origin Y to plot FSM (constant Y_POS)
//  draw_en     out  1  one-cycle start pulse to plot FSM
//  erase       out  1  1 = current pass draws background colour 3'b000
//  busy        out  1  high in every state except S_IDLE
//  error       out  1  sticky watchdog flag (0 when macro absent)
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): state=S_IDLE, x_pos=X_INIT, draw_en=0, erase=0, busy=0,
//   error=0, div_cnt=0, drawn=0. Reset mid-pass aborts the pass immediately; no pending pulse survives.
//  States:
//   S_IDLE: wait for frame_tick.
//    - drawn=0: go to S_DRAW_START (first draw, no erase).
//    - else if div_cnt==FRAMES_PER_MOVE-1: clear div_cnt, go to S_EVAL.
//    - else: div_cnt++.
//   S_EVAL: dir = right-only / left-only / none (both or neither pressed = none).
//    - compute nx; if nx==x_pos go to S_IDLE, else go to S_ERASE_START.
//   S_ERASE_START: draw_en=1, erase=1, go to S_ERASE_WAIT.
//   S_ERASE_WAIT: erase=1; on draw_done go to S_UPDATE.
//   S_UPDATE: x_pos<=nx (registered in S_EVAL), go to S_DRAW_START.
//   S_DRAW_START: draw_en=1, erase=0, drawn<=1, go to S_DRAW_WAIT.
//   S_DRAW_WAIT: on draw_done go to S_IDLE.
//  Arithmetic, 10b internally:
//   - left: nx = (x_pos < X_MIN+STEP) ? X_MIN : x_pos-STEP.
//   - right: nx = (x_pos > X_MAX-STEP) ? X_MAX : x_pos+STEP.
//   - No wrap-around ever; x_pos is always within [X_MIN, X_MAX].
//  Stability: x_pos changes only in S_UPDATE and is stable through each whole pass.
//  draw_en is exactly one cycle per pass and is never asserted outside the *_START states.
//  draw_done is sampled only in the *_WAIT states; a pulse in any other state is ignored.
//  frame_tick while busy=1 is dropped, not queued, and does not advance div_cnt.
//  Latency: tick -> first draw_en is 1 cycle (first draw) or 2 cycles (erase pass).
//   Erase draw_done -> draw draw_en is 2 cycles.
// CONFIGURATION
//  USER_MOVE_TIMEOUT_EN defined:
//   - A cycle counter runs in the *_WAIT states and clears on entering any *_START state.
//   - If it reaches TIMEOUT_CYCLES without draw_done: error<=1 (sticky until reset), go to S_IDLE.
//   - x_pos keeps its value at the time of the timeout.
//  Undefined: no counter, error tied to 0, *_WAIT states wait indefinitely.
// TESTING
//  1 Reset, first tick -> x_pos=146, one draw_en cycle with erase=0; done 560 cycles later -> busy=0.
//  2 move_right held, tick -> erase pass at x=146, then draw pass at x=148; exactly 2 draw_en pulses.
//  3 x_pos=0, move_left, tick -> no draw_en, x_pos stays 0; x_pos=291, right -> draws at 292.
//  4 Both buttons, tick -> no draw_en; FRAMES_PER_MOVE=3 -> move on every 3rd tick only.
//  5 Tick and draw_done injected during S_DRAW_WAIT/S_IDLE -> tick dropped, stray done ignored.
//   resetn low mid-erase -> x_pos=146, erase=0 next cycle.
//  6 USER_MOVE_TIMEOUT_EN: withhold draw_done -> error=1 after 1023 wait cycles, busy=0.
//   Next tick resumes normal operation.

Source files
------------

// File: rtl/user_move_ctrl.sv
// user_move_ctrl: frame-paced player X sequencer that issues erase/draw passes to the plot FSM.
// Define USER_MOVE_TIMEOUT_EN to add the sticky draw_done watchdog (error output).
module user_move_ctrl #(
  parameter int X_INIT          = 146,
  parameter int Y_POS           = 200,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 292,
  parameter int STEP            = 2,
  parameter int FRAMES_PER_MOVE = 1,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       draw_done,
  output logic [8:0] x_pos,
  output logic [7:0] y_pos,
  output logic       draw_en,
  output logic       erase,
  output logic       busy,
  output logic       error
);

  localparam logic [9:0] XMIN  = 10'(X_MIN);
  localparam logic [9:0] XMAX  = 10'(X_MAX);
  localparam logic [9:0] XSTEP = 10'(STEP);
  localparam logic [8:0] XINIT = 9'(X_INIT);

  localparam int            DW       = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAMES_PER_MOVE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_ERASE_START,
    S_ERASE_WAIT,
    S_UPDATE,
    S_DRAW_START,
    S_DRAW_WAIT
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [DW-1:0] div_cnt;
  logic          drawn;
  logic [8:0]    nx_reg;
  logic [9:0]    x_ext;
  logic [9:0]    nx;
  logic          timeout_hit;

  assign y_pos = 8'(Y_POS);

  // Candidate position; widened by one bit so the clamps never wrap.
  always_comb begin
    x_ext = {1'b0, x_pos};
    nx    = x_ext;
    if (move_right && !move_left) begin
      nx = (x_ext > XMAX - XSTEP) ? XMAX : x_ext + XSTEP;
    end else if (move_left && !move_right) begin
      nx = (x_ext < XMIN + XSTEP) ? XMIN : x_ext - XSTEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    draw_en    = 1'b0;
    erase      = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (frame_tick) begin
          if (!drawn) begin
            next_state = S_DRAW_START;
          end else if (div_cnt == DIV_LAST) begin
            next_state = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        next_state = (nx != x_ext) ? S_ERASE_START : S_IDLE;
      end
      S_ERASE_START: begin
        draw_en    = 1'b1;
        erase      = 1'b1;
        next_state = S_ERASE_WAIT;
      end
      S_ERASE_WAIT: begin
        erase = 1'b1;
        if (draw_done) begin
          next_state = S_UPDATE;
        end else if (timeout_hit) begin
          next_state = S_IDLE;
        end
      end
      S_UPDATE: begin
        next_state = S_DRAW_START;
      end
      S_DRAW_START: begin
        draw_en    = 1'b1;
        next_state = S_DRAW_WAIT;
      end
      S_DRAW_WAIT: begin
        if (draw_done) begin
          next_state = S_IDLE;
        end else if (timeout_hit) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Ticks arriving while busy never reach S_IDLE, so they are dropped without counting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_pos   <= XINIT;
      nx_reg  <= XINIT;
      div_cnt <= '0;
      drawn   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_tick && drawn) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          end
        end
        S_EVAL:       nx_reg <= nx[8:0];
        S_UPDATE:     x_pos  <= nx_reg;
        S_DRAW_START: drawn  <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef USER_MOVE_TIMEOUT_EN
  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt;
  logic          error_q;
  logic          in_wait;

  assign in_wait     = (state == S_ERASE_WAIT) || (state == S_DRAW_WAIT);
  assign timeout_hit = in_wait && !draw_done && (wait_cnt == T_LAST);
  assign error       = error_q;

  // Counter only runs inside a wait state, so every *_START entry sees it cleared.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      if (in_wait) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (timeout_hit) begin
        error_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_user_move_ctrl.sv
// tb_user_move_ctrl: cycle table for the default instance plus directed multi-cycle sequences.
// A second instance (X_INIT=291, FRAMES_PER_MOVE=3) covers the right clamp and frame division.
module tb_user_move_ctrl;

  logic clk;
  logic resetn;
  logic frame_tick;
  logic move_left;
  logic move_right;
  logic draw_done;

  logic [8:0] x_a, x_b;
  logic [7:0] y_a, y_b;
  logic       den_a, den_b, ers_a, ers_b, busy_a, busy_b, err_a, err_b;

  int checks = 0;
  int errors = 0;

  user_move_ctrl dut_a (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .move_left(move_left), .move_right(move_right), .draw_done(draw_done),
    .x_pos(x_a), .y_pos(y_a), .draw_en(den_a), .erase(ers_a),
    .busy(busy_a), .error(err_a)
  );

  user_move_ctrl #(.X_INIT(291), .FRAMES_PER_MOVE(3)) dut_b (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .move_left(move_left), .move_right(move_right), .draw_done(draw_done),
    .x_pos(x_b), .y_pos(y_b), .draw_en(den_b), .erase(ers_b),
    .busy(busy_b), .error(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       tick;
    logic       left;
    logic       right;
    logic       done;
    logic [8:0] x;
    logic       den;
    logic       ers;
    logic       bsy;
  } vec_t;

  typedef struct {
    logic left;
    logic right;
    int   pulses;
    int   x;
  } move_t;

  vec_t  vecs[34];
  move_t moves_b[10];

  function automatic vec_t mk(input int r, input int t, input int l, input int rt, input int d,
                              input int x, input int de, input int er, input int b);
    vec_t v;
    v.rstn  = r[0];
    v.tick  = t[0];
    v.left  = l[0];
    v.right = rt[0];
    v.done  = d[0];
    v.x     = x[8:0];
    v.den   = de[0];
    v.ers   = er[0];
    v.bsy   = b[0];
    return v;
  endfunction

  function automatic move_t mv(input int l, input int r, input int p, input int x);
    move_t m;
    m.left   = l[0];
    m.right  = r[0];
    m.pulses = p;
    m.x      = x;
    return m;
  endfunction

  function automatic logic [8:0] cur_x(input bit sel);
    return sel ? x_b : x_a;
  endfunction
  function automatic logic cur_den(input bit sel);
    return sel ? den_b : den_a;
  endfunction
  function automatic logic cur_ers(input bit sel);
    return sel ? ers_b : ers_a;
  endfunction
  function automatic logic cur_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  task automatic check_output(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    resetn     = v.rstn;
    frame_tick = v.tick;
    move_left  = v.left;
    move_right = v.right;
    draw_done  = v.done;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    frame_tick = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    draw_done  = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // One frame tick, then answer each draw_en with draw_done two cycles later until idle.
  task automatic run_pass(input bit sel, input logic l, input logic r, output int pulses,
                          output logic [8:0] first_x, output logic first_ers,
                          output logic [8:0] last_x, output logic last_ers);
    int since;
    int cyc;
    pulses     = 0;
    since      = -1;
    cyc        = 0;
    first_x    = '0;
    first_ers  = 1'b0;
    last_x     = '0;
    last_ers   = 1'b0;
    move_left  = l;
    move_right = r;
    frame_tick = 1'b1;
    draw_done  = 1'b0;
    step();
    frame_tick = 1'b0;
    while (cur_busy(sel) && cyc < 40) begin
      if (cur_den(sel)) begin
        if (pulses == 0) begin
          first_x   = cur_x(sel);
          first_ers = cur_ers(sel);
        end
        last_x   = cur_x(sel);
        last_ers = cur_ers(sel);
        pulses++;
        since = 0;
      end
      draw_done = (since == 2);
      step();
      draw_done = 1'b0;
      if (since >= 0) since++;
      cyc++;
    end
    check_output("pass_terminates", int'(sel), int'(cur_busy(sel)), 0);
    move_left  = 1'b0;
    move_right = 1'b0;
  endtask

  initial begin
    int         pulses;
    int         extra_den;
    int         busy_low;
    int         bad;
    int         n;
    int         wait_cycles;
    logic [8:0] fx, lx;
    logic       fe, le;

    resetn     = 1'b0;
    frame_tick = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    draw_done  = 1'b0;

    //               rstn tick L  R  done   x   den ers busy
    vecs[0]  = mk(0, 0, 0, 0, 0, 146, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 146, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 146, 1, 0, 1);
    vecs[3]  = mk(1, 0, 0, 0, 0, 146, 0, 0, 1);
    vecs[4]  = mk(1, 0, 0, 0, 1, 146, 0, 0, 0);
    vecs[5]  = mk(1, 1, 0, 1, 0, 146, 0, 0, 1);
    vecs[6]  = mk(1, 0, 0, 1, 0, 146, 1, 1, 1);
    vecs[7]  = mk(1, 0, 0, 1, 0, 146, 0, 1, 1);
    vecs[8]  = mk(1, 1, 0, 0, 0, 146, 0, 1, 1);
    vecs[9]  = mk(1, 0, 0, 0, 1, 146, 0, 0, 1);
    vecs[10] = mk(1, 0, 0, 0, 0, 148, 1, 0, 1);
    vecs[11] = mk(1, 0, 0, 0, 1, 148, 0, 0, 1);
    vecs[12] = mk(1, 1, 0, 0, 0, 148, 0, 0, 1);
    vecs[13] = mk(1, 0, 0, 0, 1, 148, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 1, 148, 0, 0, 0);
    vecs[15] = mk(1, 1, 0, 1, 0, 148, 0, 0, 1);
    vecs[16] = mk(1, 0, 0, 1, 0, 148, 1, 1, 1);
    vecs[17] = mk(1, 0, 0, 1, 0, 148, 0, 1, 1);
    vecs[18] = mk(0, 0, 0, 1, 0, 146, 0, 0, 0);
    vecs[19] = mk(1, 0, 0, 0, 1, 146, 0, 0, 0);
    vecs[20] = mk(1, 1, 0, 1, 0, 146, 1, 0, 1);
    vecs[21] = mk(1, 0, 0, 0, 0, 146, 0, 0, 1);
    vecs[22] = mk(1, 0, 0, 0, 1, 146, 0, 0, 0);
    vecs[23] = mk(1, 1, 1, 1, 0, 146, 0, 0, 1);
    vecs[24] = mk(1, 0, 1, 1, 0, 146, 0, 0, 0);
    vecs[25] = mk(1, 1, 0, 0, 0, 146, 0, 0, 1);
    vecs[26] = mk(1, 0, 0, 0, 0, 146, 0, 0, 0);
    vecs[27] = mk(1, 1, 1, 0, 0, 146, 0, 0, 1);
    vecs[28] = mk(1, 0, 1, 0, 0, 146, 1, 1, 1);
    vecs[29] = mk(1, 0, 0, 0, 1, 146, 0, 1, 1);
    vecs[30] = mk(1, 0, 0, 0, 1, 146, 0, 0, 1);
    vecs[31] = mk(1, 0, 0, 0, 0, 144, 1, 0, 1);
    vecs[32] = mk(1, 0, 0, 0, 0, 144, 0, 0, 1);
    vecs[33] = mk(1, 0, 0, 0, 1, 144, 0, 0, 0);

    for (int i = 0; i < 34; i++) begin
      apply_stimulus(vecs[i]);
      check_output("x_pos",   i, int'(x_a),    int'(vecs[i].x));
      check_output("draw_en", i, int'(den_a),  int'(vecs[i].den));
      check_output("erase",   i, int'(ers_a),  int'(vecs[i].ers));
      check_output("busy",    i, int'(busy_a), int'(vecs[i].bsy));
    end

    // First draw held for 560 cycles before draw_done arrives.
    do_reset();
    check_output("y_pos", 0, int'(y_a), 200);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check_output("first_den",  0, int'(den_a),  1);
    check_output("first_ers",  0, int'(ers_a),  0);
    check_output("first_x",    0, int'(x_a),    146);
    extra_den = 0;
    busy_low  = 0;
    for (int c = 0; c < 559; c++) begin
      step();
      if (den_a) extra_den++;
      if (!busy_a) busy_low++;
    end
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    check_output("long_wait_extra_den", 0, extra_den, 0);
    check_output("long_wait_busy_low",  0, busy_low,  0);
    check_output("long_wait_busy_end",  0, int'(busy_a), 0);
    check_output("long_wait_error",     0, int'(err_a),  0);

    // Walk left to the X_MIN clamp, then one more left must not draw.
    bad = 0;
    for (int m = 0; m < 73; m++) begin
      run_pass(1'b0, 1'b1, 1'b0, pulses, fx, fe, lx, le);
      if (pulses != 2) bad++;
    end
    check_output("left_walk_bad_passes", 0, bad, 0);
    check_output("left_walk_x", 0, int'(x_a), 0);
    run_pass(1'b0, 1'b1, 1'b0, pulses, fx, fe, lx, le);
    check_output("left_clamp_pulses", 0, pulses, 0);
    check_output("left_clamp_x",      0, int'(x_a), 0);
    run_pass(1'b0, 1'b0, 1'b1, pulses, fx, fe, lx, le);
    check_output("from_min_pulses",   0, pulses, 2);
    check_output("from_min_erase_x",  0, int'(fx), 0);
    check_output("from_min_erase_fl", 0, int'(fe), 1);
    check_output("from_min_draw_x",   0, int'(lx), 2);
    check_output("from_min_draw_fl",  0, int'(le), 0);

    // Frame division by 3 and right clamp from 291.
    moves_b[0] = mv(0, 1, 1, 291);
    moves_b[1] = mv(0, 1, 0, 291);
    moves_b[2] = mv(0, 1, 0, 291);
    moves_b[3] = mv(0, 1, 2, 292);
    moves_b[4] = mv(0, 1, 0, 292);
    moves_b[5] = mv(0, 1, 0, 292);
    moves_b[6] = mv(0, 1, 0, 292);
    moves_b[7] = mv(1, 0, 0, 292);
    moves_b[8] = mv(1, 0, 0, 292);
    moves_b[9] = mv(1, 0, 2, 290);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      run_pass(1'b1, moves_b[k].left, moves_b[k].right, pulses, fx, fe, lx, le);
      check_output("div3_pulses", k, pulses, moves_b[k].pulses);
      check_output("div3_x",      k, int'(x_b), moves_b[k].x);
      if (moves_b[k].pulses > 0) begin
        check_output("div3_draw_x", k, int'(lx), moves_b[k].x);
      end
    end

`ifdef USER_MOVE_TIMEOUT_EN
    // Withhold draw_done on the first draw and let the watchdog fire.
    do_reset();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n           = 0;
    wait_cycles = 0;
    while (busy_a && n < 2000) begin
      step();
      n++;
      if (busy_a && !den_a) wait_cycles++;
    end
    check_output("to_wait_cycles", 0, wait_cycles, 1023);
    check_output("to_error",       0, int'(err_a),  1);
    check_output("to_busy",        0, int'(busy_a), 0);
    check_output("to_x",           0, int'(x_a),    146);
    run_pass(1'b0, 1'b0, 1'b1, pulses, fx, fe, lx, le);
    check_output("to_resume_pulses", 0, pulses, 2);
    check_output("to_resume_x",      0, int'(x_a), 148);
    check_output("to_error_sticky",  0, int'(err_a), 1);
`else
    check_output("no_watchdog_error", 0, int'(err_a), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
